// File: rtl/pipe_latch_q.sv
// Elastic in-order queue between two pipeline stages with valid/ready handshake,
// flush, sticky halt capture and a saturating back-pressure cycle counter.
module pipe_latch_q #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_halt,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_halt,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         halted,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH:0]    r_mem [DEPTH];
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic              r_halted;
    logic [CNT_W-1:0]  r_stallCnt;

    logic              w_enq;
    logic              w_deq;
    logic [WIDTH:0]    w_head;
    logic [PW-1:0]     w_wrNext;
    logic [PW-1:0]     w_rdNext;

    // Full/empty is decided from the occupancy count only, so ready never
    // depends on the downstream out_ready.
    assign in_ready  = (r_count < FULL_CNT) && !r_halted;
    assign out_valid = (r_count != '0);
    assign w_enq     = in_valid && in_ready;
    assign w_deq     = out_valid && out_ready;

    // With DEPTH=1 LAST_PTR is 0, so both pointers stay pinned at 0.
    assign w_wrNext = (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PW'(1);
    assign w_rdNext = (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PW'(1);

    assign w_head    = r_mem[r_rdPtr];
    assign out_data  = out_valid ? w_head[WIDTH-1:0] : '0;
    assign out_halt  = out_valid ? w_head[WIDTH] : 1'b0;
    assign count     = r_count;
    assign halted    = r_halted;
    assign stall_cnt = r_stallCnt;

    // Flush discards everything, including a same-cycle enqueue and dequeue.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wrPtr <= w_wrNext;
            end
            if (w_deq) begin
                r_rdPtr <= w_rdNext;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CW'(1);
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Payload storage carries no reset; outputs are masked by out_valid instead.
    always_ff @(posedge CLK) begin
        if (w_enq && !flush && !RST) begin
            r_mem[r_wrPtr] <= {in_halt, in_data};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_halted <= 1'b0;
        end else if (w_enq && in_halt) begin
            r_halted <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stallCnt <= '0;
        end else if (out_valid && !out_ready && !flush && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_latch_q.sv
// Bench for pipe_latch_q: directed scenarios then random traffic, all checked
// against a queue-based reference model of the handshake rules.
module tb_pipe_latch_q;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic               CLK = 1'b0;
    logic               RST;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_halt;
    logic               in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_halt;
    logic               out_ready;
    logic               flush;
    logic [CW-1:0]      count;
    logic               halted;
    logic [CNT_W-1:0]   stall_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain queue of {halt, data} entries plus two scalars.
    logic [WIDTH:0] mQ[$];
    logic           mHalted;
    int             mStall;

    pipe_latch_q #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_data(in_data), .in_halt(in_halt), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_halt(out_halt), .out_ready(out_ready),
        .flush(flush), .count(count), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel();
        logic [WIDTH:0] head;
        head = (mQ.size() != 0) ? mQ[0] : '0;
        checkOutput("out_valid", 64'(out_valid), 64'(mQ.size() != 0));
        checkOutput("out_data",  64'(out_data),  64'(head[WIDTH-1:0]));
        checkOutput("out_halt",  64'(out_halt),  64'(head[WIDTH]));
        checkOutput("in_ready",  64'(in_ready),  64'((mQ.size() < DEPTH) && !mHalted));
        checkOutput("count",     64'(count),     64'(mQ.size()));
        checkOutput("halted",    64'(halted),    64'(mHalted));
        checkOutput("stall_cnt", 64'(stall_cnt), 64'(mStall));
    endtask

    // Drive one cycle's inputs at the falling edge, check the model, then advance
    // the model across the rising edge using the pre-edge state.
    task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] d, input logic h,
                                 input logic ordy, input logic fl, input logic rst);
        logic mValid, mReady, enq, deq;
        in_valid  = iv;
        in_data   = d;
        in_halt   = h;
        out_ready = ordy;
        flush     = fl;
        RST       = rst;
        #1;
        checkModel();
        mValid = (mQ.size() != 0);
        mReady = (mQ.size() < DEPTH) && !mHalted;
        enq    = iv && mReady;
        deq    = mValid && ordy;
        @(posedge CLK);
        if (rst) begin
            mQ.delete();
            mHalted = 1'b0;
            mStall  = 0;
        end else begin
            if (mValid && !ordy && !fl && mStall < (2 ** CNT_W - 1)) mStall++;
            if (enq && h) mHalted = 1'b1;
            if (fl) begin
                mQ.delete();
            end else begin
                if (deq) void'(mQ.pop_front());
                if (enq) mQ.push_back({h, d});
            end
        end
        @(negedge CLK);
    endtask

    initial begin
        in_valid = 0; in_data = '0; in_halt = 0; out_ready = 0; flush = 0; RST = 1;
        mHalted = 0; mStall = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 0;
        #1;
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
        checkOutput("idle_out_valid", 64'(out_valid), 64'd0);
        checkOutput("idle_out_data", 64'(out_data), 64'd0);
        checkOutput("idle_count", 64'(count), 64'd0);
        checkOutput("idle_halted", 64'(halted), 64'd0);
        checkOutput("idle_stall", 64'(stall_cnt), 64'd0);

        // Fill and back-pressure
        applyStimulus(1, 32'hA0A0A0A0, 0, 0, 0, 0);
        applyStimulus(1, 32'hB0B0B0B0, 0, 0, 0, 0);
        repeat (5) applyStimulus(1, 32'hC0C0C0C0, 0, 0, 0, 0);
        #1;
        checkOutput("fill_count", 64'(count), 64'd2);
        checkOutput("fill_in_ready", 64'(in_ready), 64'd0);
        checkOutput("fill_head", 64'(out_data), 64'hA0A0A0A0);
        checkOutput("fill_stall6", 64'(stall_cnt), 64'd6);

        // Simultaneous enqueue/dequeue at count=1
        applyStimulus(0, '0, 0, 0, 1, 0);
        applyStimulus(1, 32'h11, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 32'h22 + i, 0, 1, 0, 0);
        #1;
        checkOutput("sim_count", 64'(count), 64'd1);
        checkOutput("sim_head", 64'(out_data), 64'h29);

        // Flush priority over same-cycle enq and deq
        applyStimulus(1, 32'h12, 0, 0, 0, 0);
        applyStimulus(1, 32'h33, 0, 1, 1, 0);
        #1;
        checkOutput("flush_count", 64'(count), 64'd0);
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        repeat (2) applyStimulus(0, '0, 0, 1, 0, 0);

        // Halt capture and drain
        applyStimulus(1, 32'h44, 0, 0, 0, 0);
        applyStimulus(1, 32'h55, 1, 0, 0, 0);
        #1;
        checkOutput("halt_set", 64'(halted), 64'd1);
        checkOutput("halt_in_ready", 64'(in_ready), 64'd0);
        checkOutput("halt_head", 64'(out_data), 64'h44);
        applyStimulus(1, 32'h66, 0, 1, 0, 0);
        #1;
        checkOutput("halt_drain_data", 64'(out_data), 64'h55);
        checkOutput("halt_drain_flag", 64'(out_halt), 64'd1);
        repeat (2) applyStimulus(1, 32'h66, 0, 1, 0, 0);
        applyStimulus(0, '0, 0, 0, 1, 0);
        #1;
        checkOutput("halt_after_flush", 64'(halted), 64'd1);
        applyStimulus(0, '0, 0, 0, 0, 1);
        #1;
        checkOutput("halt_cleared", 64'(halted), 64'd0);

        // Counter saturation
        applyStimulus(1, 32'h77, 0, 0, 0, 0);
        repeat (20) applyStimulus(0, '0, 0, 0, 0, 0);
        #1;
        checkOutput("sat_stall", 64'(stall_cnt), 64'd15);
        applyStimulus(0, '0, 0, 0, 0, 0);
        #1;
        checkOutput("sat_hold", 64'(stall_cnt), 64'd15);
        applyStimulus(0, '0, 0, 0, 0, 1);
        #1;
        checkOutput("sat_reset", 64'(stall_cnt), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom(),
                          1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 29) == 0));
        end
        #1;
        checkModel();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_latch_q.md
Name: pipe_latch_q

Overview:
Parametrised, elastic successor to the fixed inter-stage pipeline latches. It is a DEPTH-entry in-order queue between two pipeline stages, with valid/ready handshaking in place of global stall/hit enables. It adds:
- a flush that discards all in-flight entries,
- a sticky halt capture that stops further intake,
- a saturating counter of downstream back-pressure cycles.

Parameters:
WIDTH, 32, payload bits per entry (instr/pc/data bundle, packed by the instantiating stage).
DEPTH, 2, number of entries; power of two, 1 to 16.
CNT_W, 16, width of the back-pressure cycle counter.

Ports:
CLK  in  1  clock; one clock domain, all state on rising edge.
RST  in  1  reset; synchronous, active-high.
in_valid  in  1  upstream presents an entry.
in_data  in  WIDTH  upstream payload.
in_halt  in  1  upstream entry is a halt instruction.
in_ready  out  1  latch can accept an entry this cycle.
out_valid  out  1  head entry is valid.
out_data  out  WIDTH  head payload.
out_halt  out  1  halt flag of head entry.
out_ready  in  1  downstream consumes head this cycle.
flush  in  1  discard all stored entries.
count  out  $clog2(DEPTH+1)  current occupancy.
halted  out  1  a halt entry has been accepted.
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (RST=1 at the edge):
  - count=0, read/write pointers=0, halted=0, stall_cnt=0.
  - Resulting outputs: out_valid=0, out_data=0, out_halt=0, in_ready=1.
  - RST overrides every other input, mid-transfer included; entries in storage are lost.
- in_ready = (count < DEPTH) && !halted.
  - Depends on registered state only; no combinational path from out_ready.
  - A full queue does not accept an entry in the same cycle as a dequeue.
- enq = in_valid && in_ready.
  - Writes {in_halt, in_data} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- deq = out_valid && out_ready.
  - rd_ptr increments modulo DEPTH.
- out_valid = (count != 0).
  - out_data/out_halt come combinationally from the entry at rd_ptr.
  - When count=0, out_data=0 and out_halt=0.
- Occupancy:
  - count changes +1 on enq only, -1 on deq only.
  - count is unchanged when enq and deq happen together (legal when 0 < count < DEPTH).
- Latency: an entry enqueued at edge N is visible at out_* after edge N; minimum in-to-out latency is 1 cycle.
- Ordering: strict FIFO; no reordering or bypass.
- Wrap-around: pointers are log2(DEPTH) bits, or a constant 0 when DEPTH=1. The full/empty decision uses count, never pointer comparison.
- Flush (flush=1 at edge, RST=0):
  - count=0, rd_ptr=wr_ptr=0.
  - Flush takes priority over a same-cycle enq and deq: the incoming entry is dropped and the head is not counted as consumed.
  - Flush does not clear halted or stall_cnt.
- Halt:
  - An enq with in_halt=1 sets halted=1 at that edge.
  - From then on in_ready=0 until RST.
  - Entries already stored, including the halt entry, still drain normally.
- stall_cnt:
  - Increments on each edge where out_valid=1, out_ready=0, flush=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by RST.
- Storage contents are not reset; only the control state is. Outputs are gated by out_valid.

Test Plan:
1. Reset and idle: RST=1 for 2 cycles, then RST=0 with in_valid=0 -> in_ready=1, out_valid=0, out_data=0, count=0, halted=0, stall_cnt=0.
2. Fill and back-pressure (DEPTH=2): enqueue 0xA0A0A0A0 then 0xB0B0B0B0 with out_ready=0 -> count=2, in_ready=0, out_data=0xA0A0A0A0. A 3rd in_valid is not accepted. Hold out_ready=0 for 5 more cycles -> stall_cnt=6.
3. Simultaneous enq/deq: at count=1 (head 0x11), enqueue 0x22 with out_ready=1 -> count stays 1, out_data=0x22 next cycle. Repeat 8 cycles with incrementing data -> strict order on out_data, pointers wrap cleanly.
4. Flush priority: count=2, drive flush=1, in_valid=1 (0x33), out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, and 0x33 never appears at the output.
5. Halt capture: enqueue 0x44 (in_halt=0), then 0x55 (in_halt=1), then keep in_valid=1 -> halted=1 and in_ready=0 after the 0x55 edge. With out_ready=1, the drain yields 0x44 (out_halt=0), then 0x55 (out_halt=1), then out_valid=0. Flush leaves halted=1; only RST clears it.
6. Counter saturation (CNT_W=4): hold head valid with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15. RST -> stall_cnt=0.
